mips32_multi_cycle: RTL and testbench

//  Multi-cycle MIPS32 integer core. Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine.

---
 rtl/mips32_multi_cycle.sv | 192 +++++++++++++++++++
 tb/tb_mips32_multi_cycle.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_multi_cycle.sv
`default_nettype none
// mips32_multi_cycle: multi-cycle MIPS32 integer core (add sub and or slt sltu addiu andi ori lw sw beq j).
// Fetch and data accesses share one req/ready memory port; illegal or misaligned accesses trap for good.
module mips32_multi_cycle #(
    parameter int          ADDR_W          = 32,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          TRAP_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       instr_o,
    output logic              retire_o,
    output logic              trap_o
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU
    } alu_op_t;

    state_t      state_q;
    logic [31:0] pc_q, pc4_q, instr_q;
    logic [31:0] a_q, b_q, imm_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];
    logic        retire_q, trap_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, dest_d;
    logic        is_rtype, is_addiu, is_andi, is_ori, is_lw, is_sw, is_beq, is_j;
    logic        legal_d, misaligned_d;
    alu_op_t     alu_op_d;
    logic [31:0] imm_d, alu_b_d, alu_d, mem_addr_d;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];

    // instr_q is stable from DECODE to retirement, so decode stays combinational
    always_comb begin
        is_rtype = (opcode == 6'h00);
        is_addiu = (opcode == 6'h09);
        is_andi  = (opcode == 6'h0C);
        is_ori   = (opcode == 6'h0D);
        is_lw    = (opcode == 6'h23);
        is_sw    = (opcode == 6'h2B);
        is_beq   = (opcode == 6'h04);
        is_j     = (opcode == 6'h02);
        alu_op_d = ALU_ADD;
        legal_d  = 1'b1;
        if (is_rtype) begin
            case (funct)
                6'h20:   alu_op_d = ALU_ADD;
                6'h22:   alu_op_d = ALU_SUB;
                6'h24:   alu_op_d = ALU_AND;
                6'h25:   alu_op_d = ALU_OR;
                6'h2A:   alu_op_d = ALU_SLT;
                6'h2B:   alu_op_d = ALU_SLTU;
                default: legal_d  = 1'b0;
            endcase
        end else if (is_andi) begin
            alu_op_d = ALU_AND;
        end else if (is_ori) begin
            alu_op_d = ALU_OR;
        end else if (!(is_addiu || is_lw || is_sw || is_beq || is_j)) begin
            legal_d = 1'b0;
        end
    end

    assign imm_d   = (is_andi || is_ori) ? {16'h0000, instr_q[15:0]}
                                         : {{16{instr_q[15]}}, instr_q[15:0]};
    assign dest_d  = is_rtype ? rd : rt;
    assign alu_b_d = is_rtype ? b_q : imm_q;

    always_comb begin
        case (alu_op_d)
            ALU_ADD:  alu_d = a_q + alu_b_d;
            ALU_SUB:  alu_d = a_q - alu_b_d;
            ALU_AND:  alu_d = a_q & alu_b_d;
            ALU_OR:   alu_d = a_q | alu_b_d;
            ALU_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(alu_b_d)};
            ALU_SLTU: alu_d = {31'd0, a_q < alu_b_d};
            default:  alu_d = '0;
        endcase
    end

    assign misaligned_d = (alu_d[1:0] != 2'b00);
    assign mem_addr_d   = TRAP_MISALIGNED ? alu_d : {alu_d[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RST;
            pc_q     <= RESET_PC;
            pc4_q    <= '0;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_RST: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready_i) begin
                        instr_q <= mem_rdata_i;
                        pc4_q   <= pc_q + 32'd4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf_q[rs];
                    b_q     <= rf_q[rt];
                    imm_q   <= imm_d;
                    state_q <= legal_d ? S_EXEC : S_TRAP;
                    trap_q  <= !legal_d;
                end
                S_EXEC: begin
                    alu_q <= (is_lw || is_sw) ? mem_addr_d : alu_d;
                    if (is_beq) begin
                        pc_q     <= (a_q == b_q) ? pc4_q + {imm_q[29:0], 2'b00} : pc4_q;
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (is_j) begin
                        pc_q     <= {pc4_q[31:28], instr_q[25:0], 2'b00};
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        if (TRAP_MISALIGNED && misaligned_d) begin
                            state_q <= S_TRAP;
                            trap_q  <= 1'b1;
                        end else begin
                            state_q <= S_MEM;
                        end
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        if (is_sw) begin
                            pc_q     <= pc4_q;
                            retire_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end else begin
                            mdr_q   <= mem_rdata_i;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dest_d != 5'd0) rf_q[dest_d] <= is_lw ? mdr_q : alu_q;
                    pc_q     <= pc4_q;
                    retire_q <= 1'b1;
                    state_q  <= S_FETCH;
                end
                S_TRAP:  trap_q <= 1'b1;
                default: begin
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                end
            endcase
        end
    end

    // Memory interface decodes straight from state so reset drops the request at once
    assign mem_req_o   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_we_o    = (state_q == S_MEM) && is_sw;
    assign mem_addr_o  = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : alu_q[ADDR_W-1:0];
    assign mem_wdata_o = b_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign retire_o    = retire_q;
    assign trap_o      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_multi_cycle.sv
`timescale 1ns/1ps
// Scoreboard bench for mips32_multi_cycle: expected data transfers and retirements are queued by the
// driver and popped by a negedge monitor as the cores present them.
module tb_mips32_multi_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        req, we, ready, retire, trap;
    logic [31:0] addr, wdata, rdata, pc, instr;
    logic        req2, we2, ready2, retire2, trap2;
    logic [31:0] addr2, wdata2, rdata2, pc2, instr2;

    mips32_multi_cycle #(.ADDR_W(32), .RESET_PC(32'h100), .TRAP_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
        .mem_wdata_o(wdata), .mem_rdata_i(rdata), .mem_ready_i(ready), .pc_o(pc),
        .instr_o(instr), .retire_o(retire), .trap_o(trap));

    mips32_multi_cycle #(.ADDR_W(32), .RESET_PC(32'h0), .TRAP_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .mem_req_o(req2), .mem_we_o(we2), .mem_addr_o(addr2),
        .mem_wdata_o(wdata2), .mem_rdata_i(rdata2), .mem_ready_i(ready2), .pc_o(pc2),
        .instr_o(instr2), .retire_o(retire2), .trap_o(trap2));

    // Memory 1: code at 0x100 and 0x01000100, data below 0x100 with three wait states
    logic [31:0] mem1 [0:511];
    logic [31:0] mem2 [0:63];
    int          wcnt1;

    assign rdata  = mem1[{addr[24], addr[9:2]}];
    assign ready  = (addr >= 32'h100) ? 1'b1 : (wcnt1 >= 3);
    assign rdata2 = mem2[addr2[7:2]];
    assign ready2 = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt1 <= 0;
        else if (req && !ready) wcnt1 <= wcnt1 + 1;
        else wcnt1 <= 0;
    end

    always @(posedge clk) begin
        if (rst_n && req && ready && we) mem1[{addr[24], addr[9:2]}] <= wdata;
        if (rst2_n && req2 && ready2 && we2) mem2[addr2[7:2]] <= wdata2;
    end

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
    typedef struct { logic [31:0] pc; int gap; } ret_t;

    xfer_t exp_x[$];
    xfer_t exp2[$];
    ret_t  exp_r[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    strict = 1'b0;
    int    cyc = 0;
    int    last_ret = 0;
    int    ret2_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_x(input string nm, input xfer_t e, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        vectors++;
        if (w !== e.we || a !== e.addr || (e.we && d !== e.data)) begin
            miscompares++;
            $display("FAIL %s: got we=%0b addr=0x%08h data=0x%08h want we=%0b addr=0x%08h data=0x%08h",
                     nm, w, a, d, e.we, e.addr, e.data);
        end
    endtask

    // Monitor: pops scoreboard entries whenever a core presents a transfer or a retirement
    initial begin
        xfer_t       e;
        ret_t        r;
        bit          waiting = 1'b0;
        logic [31:0] h_addr = '0, h_wdata = '0;
        logic        h_we = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && req && ready && addr < 32'h100) begin
                if (exp_x.size() == 0) begin
                    chk("unexpected data transfer addr", addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_x.pop_front();
                    chk_x("data transfer", e, we, addr, wdata);
                end
            end
            if (rst_n && req && !ready) begin
                if (waiting) begin
                    chk("held addr", addr, h_addr);
                    chk("held we/wdata", {31'd0, we} ^ wdata, {31'd0, h_we} ^ h_wdata);
                end
                waiting = 1'b1;
                h_addr = addr; h_we = we; h_wdata = wdata;
            end else begin
                waiting = 1'b0;
            end
            if (rst_n && retire) begin
                if (exp_r.size() > 0) begin
                    r = exp_r.pop_front();
                    chk("retire next pc", pc, r.pc);
                    if (r.gap != 0) chk("retire spacing", cyc - last_ret, r.gap);
                end else if (strict) begin
                    chk("unexpected retire pc", pc, 32'hFFFF_FFFF);
                end
                last_ret = cyc;
            end
            if (rst2_n && req2 && ready2 && exp2.size() > 0) begin
                e = exp2.pop_front();
                chk_x("core2 transfer", e, we2, addr2, wdata2);
            end
            if (rst2_n && retire2) ret2_cnt++;
        end
    end

    logic [31:0] pa;

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem1[{a[24], a[9:2]}] = w;
    endtask

    task automatic emit(input logic [31:0] w, input int gap);
        put(pa, w);
        exp_r.push_back('{pc: pa + 32'd4, gap: gap});
        pa = pa + 32'd4;
    endtask

    task automatic push_x(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_x.push_back('{we: w, addr: a, data: d});
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        for (int i = 0; i < 512; i++) mem1[i] = '0;
        for (int i = 0; i < 64; i++) mem2[i] = '0;

        pa = 32'h100;
        emit(32'h2401_0005, 0);  // addiu $1,$0,5
        emit(32'h2402_FFFD, 4);  // addiu $2,$0,-3
        emit(32'h0022_1820, 4);  // add  $3,$1,$2
        emit(32'h0041_202B, 4);  // sltu $4,$2,$1
        emit(32'hAC03_0008, 7);  // sw $3,8($0)
        emit(32'h8C05_0008, 8);  // lw $5,8($0)
        emit(32'hAC05_000C, 7);  // sw $5,12($0)
        emit(32'hAC04_0010, 7);  // sw $4,16($0)
        emit(32'h0022_3022, 4);  // sub $6,$1,$2
        emit(32'h0041_382A, 4);  // slt $7,$2,$1
        emit(32'h0022_4024, 4);  // and $8,$1,$2
        emit(32'h0022_4825, 4);  // or  $9,$1,$2
        emit(32'h304A_FFF0, 4);  // andi $10,$2,0xFFF0
        emit(32'h340B_8001, 4);  // ori  $11,$0,0x8001
        emit(32'h2420_0007, 4);  // addiu $0,$1,7
        emit(32'hAC06_0014, 7);
        emit(32'hAC07_0018, 7);
        emit(32'hAC08_001C, 7);
        emit(32'hAC09_0020, 7);
        emit(32'hAC0A_0024, 7);
        emit(32'hAC0B_0028, 7);
        emit(32'hAC00_002C, 7);
        emit(32'h0022_602B, 4);  // sltu $12,$1,$2
        emit(32'hAC0C_0030, 7);
        put(pa, 32'h0840_0040);  // j 0x0400040
        exp_r.push_back('{pc: 32'h0100_0100, gap: 3});
        put(32'h0100_0100, 32'h1021_FFFF);  // beq $1,$1,-1
        for (int i = 0; i < 4; i++) exp_r.push_back('{pc: 32'h0100_0100, gap: 3});

        push_x(1'b1, 32'h08, 32'h2);
        push_x(1'b0, 32'h08, 32'h0);
        push_x(1'b1, 32'h0C, 32'h2);
        push_x(1'b1, 32'h10, 32'h0);
        push_x(1'b1, 32'h14, 32'h8);
        push_x(1'b1, 32'h18, 32'h1);
        push_x(1'b1, 32'h1C, 32'h5);
        push_x(1'b1, 32'h20, 32'hFFFF_FFFD);
        push_x(1'b1, 32'h24, 32'h0000_FFF0);
        push_x(1'b1, 32'h28, 32'h0000_8001);
        push_x(1'b1, 32'h2C, 32'h0);
        push_x(1'b1, 32'h30, 32'h1);

        mem2[0] = 32'h8C01_0002;  // lw $1,2($0): address forced to 0
        mem2[1] = 32'hAC01_0040;  // sw $1,0x40($0)
        mem2[2] = 32'h1000_FFFF;  // beq $0,$0,-1
        exp2.push_back('{we: 1'b0, addr: 32'h0,  data: 32'h0});
        exp2.push_back('{we: 1'b0, addr: 32'h0,  data: 32'h0});
        exp2.push_back('{we: 1'b0, addr: 32'h4,  data: 32'h0});
        exp2.push_back('{we: 1'b1, addr: 32'h40, data: 32'h8C01_0002});
        exp2.push_back('{we: 1'b0, addr: 32'h8,  data: 32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pc", pc, 32'h100);
        chk("reset instr", instr, 32'h0);
        chk("reset req/we", {30'd0, req, we}, 32'h0);
        chk("reset retire/trap", {30'd0, retire, trap}, 32'h0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        strict = 1'b1;
        @(negedge clk);
        chk("first fetch req/we", {30'd0, req, we}, 32'h2);
        chk("first fetch addr", addr, 32'h100);

        for (int i = 0; i < 3000 && exp_r.size() > 0; i++) @(negedge clk);
        chk("retirements outstanding", exp_r.size(), 0);
        strict = 1'b0;
        chk("data transfers outstanding", exp_x.size(), 0);

        // Reset in the middle of a pending fetch
        bad = 1;
        for (int i = 0; i < 20 && bad == 1; i++) begin
            @(negedge clk);
            if (req) bad = 0;
        end
        chk("loop fetch seen", bad, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset drops req", {31'd0, req}, 32'h0);
        chk("async reset pc", pc, 32'h100);
        put(32'h100, 32'hFC00_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart fetch addr", {req, addr[30:0]}, {1'b1, 31'h100});
        @(negedge clk);
        chk("trap low in decode", {31'd0, trap}, 32'h0);
        @(negedge clk);
        chk("trap after decode", {31'd0, trap}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("trap hold req/trap", {30'd0, req, trap}, 32'h1);
            chk("trap hold pc", pc, 32'h100);
        end
        chk("trap instr", instr, 32'hFC00_0000);

        // Misaligned load traps without a data request
        #1 rst_n = 1'b0;
        put(32'h100, 32'h8C01_0002);
        #1;
        chk("reset clears trap", {31'd0, trap}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req && addr != 32'h100) bad++;
        end
        chk("misaligned lw data reqs", bad, 0);
        chk("misaligned lw trap/req", {30'd0, trap, req}, 32'h2);
        chk("misaligned lw pc", pc, 32'h100);

        chk("core2 transfers outstanding", exp2.size(), 0);
        chk("core2 trap", {31'd0, trap2}, 32'h0);
        chk("core2 loop pc", pc2, 32'h8);
        chk("core2 loop instr", instr2, 32'h1000_FFFF);
        chk("core2 retired several", {31'd0, ret2_cnt > 2}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
